arbitro_vram: RTL and testbench
===============================

Name: arbitro_vram

Overview:
- Arbiter and sequencer for a single-port text/video RAM shared between the VGA display fetch path and a host writer.
- Consumes pixel_X, pixel_Y, video_on and p_tick from the VGA sync generator and converts pixel position to a character-cell address.
- Display reads have absolute priority on pixel ticks. Host writes use idle slots through a req/ack handshake.
- Outputs the fetched character code, aligned with delayed in-cell coordinates, to the pixel/font generator.

Parameters:
ADDR_W, 12, RAM address width
DATA_W, 8, RAM data width (character code)
COLS, 80, character cells per row
ROWS, 30, character rows; DEPTH = COLS*ROWS = 2400
CW_LOG, 3, log2 of cell width in pixels (8)
CH_LOG, 4, log2 of cell height in pixels (16)
SOLO_BLANK, 0, when 1, host writes are granted only while video_on=0

Ports:
CLK  in  1  system clock (50 MHz)
RESET  in  1  asynchronous, active-high reset
p_tick  in  1  pixel enable from sync generator (high every 2nd CLK)
video_on  in  1  visible-area flag
pixel_X  in  10  horizontal pixel position
pixel_Y  in  10  vertical pixel position
wr_req  in  1  host write request, held high until wr_ack seen
wr_addr  in  ADDR_W  host write address, stable while wr_req=1
wr_data  in  DATA_W  host write data, stable while wr_req=1
wr_ack  out  1  one-cycle write-complete pulse
wr_err  out  1  one-cycle pulse with wr_ack when wr_addr >= DEPTH
mem_en  out  1  RAM enable (registered)
mem_we  out  1  RAM write enable (registered)
mem_addr  out  ADDR_W  RAM address (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data; valid 1 CLK after mem_en with mem_we=0
char_code  out  DATA_W  fetched character
char_valid  out  1  char_code valid this cycle
cell_col  out  CW_LOG  pixel_X[CW_LOG-1:0], delayed to align with char_code
cell_row  out  CH_LOG  pixel_Y[CH_LOG-1:0], delayed to align with char_code
stall_cnt  out  16  cycles the current request has waited, saturating

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pipeline valid bits cleared, pending write dropped. Reset asserted mid-operation has the same effect immediately.
- Display address: disp_addr = pixel_Y[9:CH_LOG]*COLS + pixel_X[9:CW_LOG], computed at ADDR_W width. The maximum value is 2399.
- Display claim: disp_claim = p_tick & video_on.
  - On the next edge: mem_en=1, mem_we=0, mem_addr=disp_addr.
  - The claim always wins over a host write in the same cycle.
- Display pipeline:
  - Read issued at edge t.
  - mem_rdata is registered into char_code at edge t+1, with char_valid=1 for exactly one cycle.
  - cell_col and cell_row pass through a 2-stage delay from the claim cycle.
  - char_valid is otherwise 0; char_code holds its last value.
- FSM states:
  - IDLE: grant when wr_req=1, disp_claim=0, and (SOLO_BLANK=0 or video_on=0).
    - On grant, if wr_addr < DEPTH, issue mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data. Otherwise mem_en=0.
    - Go to ACK.
    - If not granted while wr_req=1, stay in IDLE and increment stall_cnt, saturating at 65535.
  - ACK: wr_ack=1 for one cycle; wr_err=1 if the address was out of range. stall_cnt clears to 0. Go to HOLD.
  - HOLD: wait for wr_req=0, then go to IDLE. A request held high never produces a second write.
- mem_en=0 and mem_we=0 in any cycle with neither a claim nor a grant. mem_addr and mem_wdata hold their last values.
- Throughput: with SOLO_BLANK=0, a write is granted within at most 1 cycle, because claims never occur on consecutive CLK edges.
- No combinational path from wr_req to the mem_* outputs. All mem_* outputs are registered.

Test Plan:
- Reset, then idle frame with pixel_X=0, pixel_Y=0, video_on=1, p_tick toggling → mem_addr=0, mem_we=0. With mem_rdata=8'h41 returned, char_code=8'h41 and char_valid pulses once every 2 CLK.
- pixel_X=639, pixel_Y=479 on a tick → mem_addr=2399. The cell_col=7 and cell_row=15 outputs align with char_valid.
- wr_req with wr_addr=100 and wr_data=8'h5A raised in the same cycle as a display claim → the display read is issued first. The write is issued the next cycle, wr_ack pulses 1 cycle later, and stall_cnt is 1 before clearing.
- SOLO_BLANK=1, wr_req raised during video_on=1 → no write and stall_cnt counts. After video_on falls, the write is issued within 1 cycle and wr_ack fires.
- wr_addr=3000 → wr_ack and wr_err pulse together with no mem_en write. With wr_req held high for 10 cycles after the ack, no second ack or write occurs.
- RESET asserted while in ACK → wr_ack=0, char_valid=0, and stall_cnt=0 immediately. A new request after reset is serviced normally.

Source files
------------

// File: rtl/arbitro_vram.sv
// VRAM arbiter: shares a single-port text RAM between the VGA character fetch
// path (absolute priority on pixel ticks) and a host writer using req/ack.
module arbitro_vram #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int CW_LOG     = 3,
  parameter int CH_LOG     = 4,
  parameter int SOLO_BLANK = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_X,
  input  logic [9:0]        pixel_Y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] char_code,
  output logic              char_valid,
  output logic [CW_LOG-1:0] cell_col,
  output logic [CH_LOG-1:0] cell_row,
  output logic [15:0]       stall_cnt
);

  localparam int DEPTH = COLS * ROWS;
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    HOLD
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] row_idx;
  logic [ADDR_W-1:0] col_idx;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_claim;
  logic              addr_ok;
  logic              grant;
  logic              ack_next;
  logic              err_next;
  logic              err_pend;
  logic              rd_pend;
  logic [CW_LOG-1:0] col_d1;
  logic [CH_LOG-1:0] row_d1;

  // Character-cell address of the pixel currently being scanned.
  assign row_idx    = ADDR_W'(pixel_Y >> CH_LOG);
  assign col_idx    = ADDR_W'(pixel_X >> CW_LOG);
  assign disp_addr  = row_idx * COLS_A + col_idx;
  assign disp_claim = p_tick & video_on;
  assign addr_ok    = ({1'b0, wr_addr} < DEPTH_A);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Host writes only take slots the display did not claim.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req && !disp_claim && ((SOLO_BLANK == 0) || !video_on)) begin
          grant      = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        ack_next   = 1'b1;
        err_next   = err_pend;
        state_next = HOLD;
      end
      HOLD: begin
        if (!wr_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (disp_claim) begin
        mem_en   <= 1'b1;
        mem_addr <= disp_addr;
      end else if (grant && addr_ok) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_pend  <= 1'b0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      wr_ack <= ack_next;
      wr_err <= err_next;
      if (grant) err_pend <= !addr_ok;
      if (state == ACK)
        stall_cnt <= '0;
      else if ((state == IDLE) && wr_req && !grant && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // In-cell coordinates ride a 2-deep delay so they line up with char_code.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_pend    <= 1'b0;
      col_d1     <= '0;
      row_d1     <= '0;
      char_valid <= 1'b0;
      char_code  <= '0;
      cell_col   <= '0;
      cell_row   <= '0;
    end else begin
      rd_pend    <= disp_claim;
      col_d1     <= pixel_X[CW_LOG-1:0];
      row_d1     <= pixel_Y[CH_LOG-1:0];
      char_valid <= rd_pend;
      if (rd_pend) char_code <= mem_rdata;
      cell_col <= col_d1;
      cell_row <= row_d1;
    end
  end

endmodule

// File: tb/tb_arbitro_vram.sv
// Directed bench for arbitro_vram: table-driven display fetches plus
// hand-written write/arbitration/reset sequences on two parameterisations.
module tb_arbitro_vram;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        p_tick, video_on;
  logic [9:0]  pixel_X, pixel_Y;
  logic [7:0]  mem_rdata;

  logic        wr_req, wr_ack, wr_err, mem_en, mem_we, char_valid;
  logic [11:0] wr_addr, mem_addr;
  logic [7:0]  wr_data, mem_wdata, char_code;
  logic [2:0]  cell_col;
  logic [3:0]  cell_row;
  logic [15:0] stall_cnt;

  logic        wr_req_b, wr_ack_b, wr_err_b, mem_en_b, mem_we_b, char_valid_b;
  logic [11:0] wr_addr_b, mem_addr_b;
  logic [7:0]  wr_data_b, mem_wdata_b, char_code_b;
  logic [2:0]  cell_col_b;
  logic [3:0]  cell_row_b;
  logic [15:0] stall_cnt_b;

  int checks   = 0;
  int failures = 0;

  always #10 CLK = ~CLK;

  arbitro_vram #(.SOLO_BLANK(0)) dut (
    .CLK(CLK), .RESET(RESET), .p_tick(p_tick), .video_on(video_on),
    .pixel_X(pixel_X), .pixel_Y(pixel_Y),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .char_code(char_code), .char_valid(char_valid),
    .cell_col(cell_col), .cell_row(cell_row), .stall_cnt(stall_cnt)
  );

  arbitro_vram #(.SOLO_BLANK(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .p_tick(p_tick), .video_on(video_on),
    .pixel_X(pixel_X), .pixel_Y(pixel_Y),
    .wr_req(wr_req_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .wr_ack(wr_ack_b), .wr_err(wr_err_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata),
    .char_code(char_code_b), .char_valid(char_valid_b),
    .cell_col(cell_col_b), .cell_row(cell_row_b), .stall_cnt(stall_cnt_b)
  );

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic [7:0]  rdata;
    logic [11:0] exp_addr;
    logic [2:0]  exp_col;
    logic [3:0]  exp_row;
  } disp_vec_t;

  disp_vec_t vecs[8];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    vecs[0] = '{10'd0,   10'd0,   8'h41, 12'd0,    3'd0, 4'd0};
    vecs[1] = '{10'd0,   10'd0,   8'h41, 12'd0,    3'd0, 4'd0};
    vecs[2] = '{10'd639, 10'd479, 8'h5B, 12'd2399, 3'd7, 4'd15};
    vecs[3] = '{10'd8,   10'd16,  8'h13, 12'd81,   3'd0, 4'd0};
    vecs[4] = '{10'd100, 10'd200, 8'hC4, 12'd972,  3'd4, 4'd8};
    vecs[5] = '{10'd321, 10'd47,  8'h2E, 12'd200,  3'd1, 4'd15};
    vecs[6] = '{10'd639, 10'd0,   8'h7F, 12'd79,   3'd7, 4'd0};
    vecs[7] = '{10'd0,   10'd479, 8'hE1, 12'd2320, 3'd0, 4'd15};

    RESET = 1'b1; p_tick = 1'b0; video_on = 1'b0;
    pixel_X = '0; pixel_Y = '0; mem_rdata = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    wr_req_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    repeat (2) @(negedge CLK);

    check_output("reset_mem_en", mem_en, 1'b0);
    check_output("reset_mem_addr", mem_addr, 12'd0);
    check_output("reset_wr_ack", wr_ack, 1'b0);
    check_output("reset_char_valid", char_valid, 1'b0);
    check_output("reset_char_code", char_code, 8'h00);
    check_output("reset_stall", stall_cnt, 16'd0);
    check_output("reset_b_mem_en", mem_en_b, 1'b0);
    RESET = 1'b0;
    step();

    // Display fetches: tick cycle issues the read, next cycle delivers the code.
    video_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pixel_X = vecs[i].px; pixel_Y = vecs[i].py; p_tick = 1'b1;
      step();
      check_output($sformatf("disp%0d_mem_en", i), mem_en, 1'b1);
      check_output($sformatf("disp%0d_mem_we", i), mem_we, 1'b0);
      check_output($sformatf("disp%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
      check_output($sformatf("disp%0d_valid_low", i), char_valid, 1'b0);
      p_tick = 1'b0; mem_rdata = vecs[i].rdata;
      step();
      check_output($sformatf("disp%0d_en_idle", i), mem_en, 1'b0);
      check_output($sformatf("disp%0d_valid", i), char_valid, 1'b1);
      check_output($sformatf("disp%0d_code", i), char_code, vecs[i].rdata);
      check_output($sformatf("disp%0d_col", i), cell_col, vecs[i].exp_col);
      check_output($sformatf("disp%0d_row", i), cell_row, vecs[i].exp_row);
    end
    step();
    check_output("valid_single_pulse", char_valid, 1'b0);
    check_output("code_holds", char_code, 8'hE1);

    // Tick outside the visible area does not touch the RAM.
    video_on = 1'b0; p_tick = 1'b1;
    step();
    check_output("blank_tick_no_en", mem_en, 1'b0);
    p_tick = 1'b0;
    step();
    check_output("blank_tick_no_valid", char_valid, 1'b0);

    // Write request colliding with a display claim.
    video_on = 1'b1; pixel_X = 10'd8; pixel_Y = 10'd16; p_tick = 1'b1;
    wr_req = 1'b1; wr_addr = 12'd100; wr_data = 8'h5A;
    step();
    check_output("coll_read_first_we", mem_we, 1'b0);
    check_output("coll_read_first_addr", mem_addr, 12'd81);
    check_output("coll_stall1", stall_cnt, 16'd1);
    check_output("coll_no_ack_yet", wr_ack, 1'b0);
    p_tick = 1'b0; mem_rdata = 8'h77;
    step();
    check_output("coll_write_en", mem_en, 1'b1);
    check_output("coll_write_we", mem_we, 1'b1);
    check_output("coll_write_addr", mem_addr, 12'd100);
    check_output("coll_write_data", mem_wdata, 8'h5A);
    check_output("coll_stall_held", stall_cnt, 16'd1);
    check_output("coll_char_code", char_code, 8'h77);
    check_output("coll_ack_not_early", wr_ack, 1'b0);
    step();
    check_output("coll_ack", wr_ack, 1'b1);
    check_output("coll_err", wr_err, 1'b0);
    check_output("coll_stall_clear", stall_cnt, 16'd0);
    check_output("coll_en_after", mem_en, 1'b0);
    wr_req = 1'b0;
    step();
    check_output("coll_ack_one_cycle", wr_ack, 1'b0);
    step();

    // Out-of-range write held high well past its ack.
    wr_req = 1'b1; wr_addr = 12'd3000; wr_data = 8'hAA;
    step();
    check_output("oor_no_en", mem_en, 1'b0);
    check_output("oor_no_we", mem_we, 1'b0);
    step();
    check_output("oor_ack", wr_ack, 1'b1);
    check_output("oor_err", wr_err, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      check_output($sformatf("hold%0d_no_ack", i), wr_ack, 1'b0);
      check_output($sformatf("hold%0d_no_err", i), wr_err, 1'b0);
      check_output($sformatf("hold%0d_no_en", i), mem_en, 1'b0);
      check_output($sformatf("hold%0d_stall", i), stall_cnt, 16'd0);
    end
    wr_req = 1'b0;
    step();
    step();

    // Blank-only writer stalls while visible, then writes after video_on falls.
    video_on = 1'b1; p_tick = 1'b0;
    wr_req_b = 1'b1; wr_addr_b = 12'd200; wr_data_b = 8'hC3;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_output($sformatf("solo_stall%0d", i), stall_cnt_b, 32'(i));
      check_output($sformatf("solo_no_en%0d", i), mem_en_b, 1'b0);
    end
    video_on = 1'b0;
    step();
    check_output("solo_write_we", mem_we_b, 1'b1);
    check_output("solo_write_addr", mem_addr_b, 12'd200);
    check_output("solo_write_data", mem_wdata_b, 8'hC3);
    step();
    check_output("solo_ack", wr_ack_b, 1'b1);
    check_output("solo_stall_clear", stall_cnt_b, 16'd0);
    wr_req_b = 1'b0;
    step();

    // Reset while the write is in ACK.
    video_on = 1'b1; pixel_X = 10'd0; pixel_Y = 10'd0; p_tick = 1'b1;
    wr_req = 1'b1; wr_addr = 12'd5; wr_data = 8'h11;
    step();
    p_tick = 1'b0; mem_rdata = 8'h99;
    step();
    check_output("pre_rst_we", mem_we, 1'b1);
    check_output("pre_rst_valid", char_valid, 1'b1);
    RESET = 1'b1;
    #1;
    check_output("rst_valid", char_valid, 1'b0);
    check_output("rst_stall", stall_cnt, 16'd0);
    check_output("rst_mem_en", mem_en, 1'b0);
    check_output("rst_char_code", char_code, 8'h00);
    step();
    check_output("rst_no_ack", wr_ack, 1'b0);
    check_output("rst_no_err", wr_err, 1'b0);
    RESET = 1'b0; wr_addr = 12'd6; wr_data = 8'h22;
    step();
    check_output("post_rst_we", mem_we, 1'b1);
    check_output("post_rst_addr", mem_addr, 12'd6);
    check_output("post_rst_data", mem_wdata, 8'h22);
    step();
    check_output("post_rst_ack", wr_ack, 1'b1);
    wr_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
